// File: rtl/quantum_scheduler.sv
// ---------------------------------------------------------------------------
// quantum_scheduler
//
// Preemptive round-robin time-slice controller that sits beside the CPU
// PC-update logic. It counts retired instructions of the running process.
// When the quantum expires it saves the running PC and steers the CPU to the
// scheduler routine. When the scheduler software pulses sched_done, it
// dispatches the next valid process by forcing that process's saved PC into
// the CPU.
//
// Ports:
//   clock            in   system clock; all state updates on the rising edge
//   reset            in   asynchronous, active-low
//   enable           in   1 = preemption armed; 0 = counting frozen, no switches
//   retire           in   CPU advanced its PC this cycle
//   pc_atual         in   current CPU PC
//   sched_done       in   one-cycle pulse from the scheduler: pick and dispatch
//   cfg_we           in   process-table write strobe
//   cfg_id           in   slot being written
//   cfg_valid        in   valid bit written into the slot
//   cfg_pc           in   initial PC written into the slot's saved-PC entry
//   mudancaContexto  out  00 normal, 11 jump to scheduler, 10 load next_pc
//   next_pc          out  SCHED_ADDR during SWITCH, saved PC during DISPATCH
//   proc_atual       out  id of the running process
//   quantum_cnt      out  retired-instruction count in the current slice
//   idle             out  scheduler found no valid process to dispatch
// ---------------------------------------------------------------------------
module quantum_scheduler #(
  parameter int                    NUM_PROC   = 4,
  parameter int                    QUANTUM    = 64,
  parameter int                    PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   SCHED_ADDR = '0,
  localparam int                   ID_W       = $clog2(NUM_PROC),
  localparam int                   CNT_W      = $clog2(QUANTUM) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                retire,
  input  logic [PC_WIDTH-1:0] pc_atual,
  input  logic                sched_done,
  input  logic                cfg_we,
  input  logic [ID_W-1:0]     cfg_id,
  input  logic                cfg_valid,
  input  logic [PC_WIDTH-1:0] cfg_pc,
  output logic [1:0]          mudancaContexto,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic [ID_W-1:0]     proc_atual,
  output logic [CNT_W-1:0]    quantum_cnt,
  output logic                idle
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SWITCH,
    ST_SCHED,
    ST_DISPATCH
  } state_t;

  localparam logic [1:0] MC_NORMAL = 2'b00;
  localparam logic [1:0] MC_SCHED  = 2'b11;
  localparam logic [1:0] MC_LOAD   = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

  state_t state;

  // Process table
  logic [NUM_PROC-1:0] valid;
  logic [PC_WIDTH-1:0] saved [NUM_PROC];

  // -------------------------------------------------------------------------
  // Round-robin candidate search. Candidate gi is slot proc_atual+1+gi,
  // wrapping naturally because NUM_PROC is a power of two; the last
  // candidate is therefore the running slot itself, so a lone valid process
  // gets re-dispatched.
  // -------------------------------------------------------------------------
  logic [ID_W-1:0]     cand_id [NUM_PROC];
  logic [NUM_PROC-1:0] cand_ok;

  generate
    for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_cand
      assign cand_id[gi] = proc_atual + ID_W'(gi + 1);
      assign cand_ok[gi] = valid[cand_id[gi]];
    end
  endgenerate

  logic            found;
  logic [ID_W-1:0] sel_id;

  // Lowest candidate index wins: walk downward so the last hit is the nearest.
  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (cand_ok[i]) begin
        found  = 1'b1;
        sel_id = cand_id[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Slice control. A config write landing on the running slot this cycle
  // takes effect immediately, so clearing its valid bit preempts at once.
  // -------------------------------------------------------------------------
  logic cur_valid_eff;
  logic cnt_at_last;
  logic expire;
  logic preempt;

  assign cur_valid_eff = (cfg_we && (cfg_id == proc_atual)) ? cfg_valid
                                                            : valid[proc_atual];
  assign cnt_at_last   = (quantum_cnt == CNT_LAST);
  assign expire        = retire && cnt_at_last;
  assign preempt       = !cur_valid_eff || expire;

  // -------------------------------------------------------------------------
  // Process table. The SWITCH save is written after the config write so it
  // wins on the PC when both hit the running slot; the valid bit is only
  // ever written by configuration.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < NUM_PROC; i++) begin
        saved[i] <= '0;
      end
    end else begin
      if (cfg_we) begin
        valid[cfg_id] <= cfg_valid;
        saved[cfg_id] <= cfg_pc;
      end
      if (state == ST_SWITCH) begin
        // pc_atual here is the first unexecuted instruction of the process
        saved[proc_atual] <= pc_atual;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs. Outputs change on the same edge the
  // state is entered, so mudancaContexto is visible for the whole SWITCH or
  // DISPATCH cycle and the CPU samples it on the following edge.
  // next_pc keeps its last value outside SWITCH and DISPATCH.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      mudancaContexto <= MC_NORMAL;
      next_pc         <= '0;
      proc_atual      <= '0;
      quantum_cnt     <= '0;
      idle            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            if (valid[proc_atual]) begin
              state <= ST_RUN;
            end else begin
              // nothing runnable: let the scheduler software choose
              state           <= ST_SWITCH;
              mudancaContexto <= MC_SCHED;
              next_pc         <= SCHED_ADDR;
            end
          end
        end

        ST_RUN: begin
          if (enable) begin
            // count saturates at QUANTUM-1; the retire that finds it there
            // is the last instruction of the slice
            if (retire && !cnt_at_last) begin
              quantum_cnt <= quantum_cnt + CNT_W'(1);
            end
            if (preempt) begin
              state           <= ST_SWITCH;
              mudancaContexto <= MC_SCHED;
              next_pc         <= SCHED_ADDR;
            end
          end
        end

        ST_SWITCH: begin
          state           <= ST_SCHED;
          mudancaContexto <= MC_NORMAL;
        end

        ST_SCHED: begin
          if (sched_done) begin
            if (found) begin
              state           <= ST_DISPATCH;
              mudancaContexto <= MC_LOAD;
              next_pc         <= saved[sel_id];
              proc_atual      <= sel_id;
              quantum_cnt     <= '0;
              idle            <= 1'b0;
            end else begin
              // stay here; a later pulse retries after the table changes
              idle <= 1'b1;
            end
          end
        end

        ST_DISPATCH: begin
          state           <= ST_RUN;
          mudancaContexto <= MC_NORMAL;
        end

        default: begin
          state           <= ST_IDLE;
          mudancaContexto <= MC_NORMAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quantum_scheduler.sv
// ---------------------------------------------------------------------------
// tb_quantum_scheduler
//
// Directed scenarios with literal expectations followed by randomized
// stimulus. A behavioural reference model of the time-slice rules is
// advanced on every rising edge and compared against all DUT outputs one
// cycle at a time.
// ---------------------------------------------------------------------------
module tb_quantum_scheduler;

  localparam int          NP = 4;
  localparam int          Q  = 4;
  localparam int          PW = 32;
  localparam logic [31:0] SA = 32'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] pc_atual = '0;
  logic        sched_done = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_id = '0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_pc = '0;

  logic [1:0]  mudancaContexto;
  logic [31:0] next_pc;
  logic [1:0]  proc_atual;
  logic [2:0]  quantum_cnt;
  logic        idle;

  int n_cmp  = 0;
  int n_fail = 0;

  quantum_scheduler #(
    .NUM_PROC   (NP),
    .QUANTUM    (Q),
    .PC_WIDTH   (PW),
    .SCHED_ADDR (SA)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .retire          (retire),
    .pc_atual        (pc_atual),
    .sched_done      (sched_done),
    .cfg_we          (cfg_we),
    .cfg_id          (cfg_id),
    .cfg_valid       (cfg_valid),
    .cfg_pc          (cfg_pc),
    .mudancaContexto (mudancaContexto),
    .next_pc         (next_pc),
    .proc_atual      (proc_atual),
    .quantum_cnt     (quantum_cnt),
    .idle            (idle)
  );

  always #5 clock = ~clock;

  // ------------------------------------------------------------------
  // Reference model: phase of the slice protocol plus the process table
  // ------------------------------------------------------------------
  localparam int P_IDLE = 0, P_RUN = 1, P_SWITCH = 2, P_SCHED = 3, P_DISPATCH = 4;

  int          m_phase;
  bit          m_valid [NP];
  logic [31:0] m_saved [NP];
  int          m_cur;
  int          m_cnt;
  bit          m_idle;
  logic [1:0]  m_mc;
  logic [31:0] m_npc;

  task automatic model_reset();
    m_phase = P_IDLE;
    for (int i = 0; i < NP; i++) begin
      m_valid[i] = 1'b0;
      m_saved[i] = '0;
    end
    m_cur  = 0;
    m_cnt  = 0;
    m_idle = 1'b0;
    m_mc   = 2'b00;
    m_npc  = '0;
  endtask

  task automatic model_step();
    bit          ov [NP];
    logic [31:0] os [NP];
    bit          still;
    bit          expire;
    int          pick;
    ov = m_valid;
    os = m_saved;
    if (cfg_we) begin
      m_valid[int'(cfg_id)] = cfg_valid;
      m_saved[int'(cfg_id)] = cfg_pc;
    end
    case (m_phase)
      P_IDLE: begin
        if (enable) begin
          if (ov[m_cur]) m_phase = P_RUN;
          else begin
            m_phase = P_SWITCH; m_mc = 2'b11; m_npc = SA;
          end
        end
      end
      P_RUN: begin
        if (enable) begin
          still  = (cfg_we && int'(cfg_id) == m_cur) ? cfg_valid : ov[m_cur];
          expire = retire && (m_cnt == Q - 1);
          if (retire && m_cnt < Q - 1) m_cnt = m_cnt + 1;
          if (!still || expire) begin
            m_phase = P_SWITCH; m_mc = 2'b11; m_npc = SA;
          end
        end
      end
      P_SWITCH: begin
        m_saved[m_cur] = pc_atual;
        m_phase = P_SCHED;
        m_mc    = 2'b00;
      end
      P_SCHED: begin
        if (sched_done) begin
          pick = -1;
          for (int k = 1; k <= NP; k++) begin
            if (pick < 0 && ov[(m_cur + k) % NP]) pick = (m_cur + k) % NP;
          end
          if (pick >= 0) begin
            m_phase = P_DISPATCH; m_mc = 2'b10; m_npc = os[pick];
            m_cur = pick; m_cnt = 0; m_idle = 1'b0;
          end else begin
            m_idle = 1'b1;
          end
        end
      end
      default: begin
        m_phase = P_RUN;
        m_mc    = 2'b00;
      end
    endcase
  endtask

  // Cycle-by-cycle compare against the model
  always @(posedge clock) begin
    if (!reset) model_reset();
    else        model_step();
    #1;
    n_cmp++;
    if ({mudancaContexto, next_pc, proc_atual, quantum_cnt, idle} !==
        {m_mc, m_npc, 2'(m_cur), 3'(m_cnt), m_idle}) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t: got mc=%b npc=%h proc=%0d cnt=%0d idle=%b, expected mc=%b npc=%h proc=%0d cnt=%0d idle=%b",
               $time, mudancaContexto, next_pc, proc_atual, quantum_cnt, idle,
               m_mc, m_npc, m_cur, m_cnt, m_idle);
    end
  end

  // ------------------------------------------------------------------
  // Helpers
  // ------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, return just after the
  // rising edge that consumed them.
  task automatic drive(input bit en, input bit ret, input logic [31:0] pc,
                       input bit sd, input bit we, input logic [1:0] id,
                       input bit v, input logic [31:0] cpc);
    @(negedge clock);
    enable     = en;
    retire     = ret;
    pc_atual   = pc;
    sched_done = sd;
    cfg_we     = we;
    cfg_id     = id;
    cfg_valid  = v;
    cfg_pc     = cpc;
    @(posedge clock);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mc"},   32'(mudancaContexto), 32'h0);
    chk({tag, "_npc"},  next_pc,              32'h0);
    chk({tag, "_proc"}, 32'(proc_atual),      32'h0);
    chk({tag, "_cnt"},  32'(quantum_cnt),     32'h0);
    chk({tag, "_idle"}, 32'(idle),            32'h0);
  endtask

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset_vals("reset_state");

    // slot 0 at 0x10, slot 1 at 0x40
    drive(0, 0, 32'h0, 0, 1, 2'd0, 1, 32'h10);
    drive(0, 0, 32'h0, 0, 1, 2'd1, 1, 32'h40);
    drive(1, 0, 32'h10, 0, 0, 2'd0, 0, 32'h0);          // IDLE -> RUN
    chk("idle_to_run_mc", 32'(mudancaContexto), 32'h0);
    for (int i = 0; i < 3; i++) drive(1, 1, 32'h10 + 32'(i), 0, 0, 2'd0, 0, 32'h0);
    chk("cnt_after_3", 32'(quantum_cnt), 32'd3);
    drive(1, 1, 32'h13, 0, 0, 2'd0, 0, 32'h0);          // 4th retire
    chk("expire_mc",   32'(mudancaContexto), 32'h3);
    chk("expire_npc",  next_pc,              32'h0);
    chk("expire_cnt",  32'(quantum_cnt),     32'd3);
    drive(1, 0, 32'h14, 0, 0, 2'd0, 0, 32'h0);          // SWITCH saves 0x14
    chk("sched_mc", 32'(mudancaContexto), 32'h0);
    drive(1, 0, 32'h14, 1, 0, 2'd0, 0, 32'h0);          // sched_done
    chk("disp1_mc",   32'(mudancaContexto), 32'h2);
    chk("disp1_npc",  next_pc,              32'h40);
    chk("disp1_proc", 32'(proc_atual),      32'd1);
    chk("disp1_cnt",  32'(quantum_cnt),     32'd0);
    drive(1, 0, 32'h40, 0, 0, 2'd0, 0, 32'h0);
    chk("run1_mc", 32'(mudancaContexto), 32'h0);

    // pause mid-slice, then freeze with enable low
    drive(1, 1, 32'h40, 0, 0, 2'd0, 0, 32'h0);
    drive(1, 1, 32'h41, 0, 0, 2'd0, 0, 32'h0);
    repeat (10) drive(1, 0, 32'h42, 0, 0, 2'd0, 0, 32'h0);
    chk("no_retire_cnt", 32'(quantum_cnt), 32'd2);
    repeat (3) drive(0, 1, 32'h42, 0, 0, 2'd0, 0, 32'h0);
    chk("frozen_cnt", 32'(quantum_cnt), 32'd2);
    chk("frozen_mc",  32'(mudancaContexto), 32'h0);
    drive(1, 1, 32'h42, 0, 0, 2'd0, 0, 32'h0);
    drive(1, 1, 32'h43, 0, 0, 2'd0, 0, 32'h0);
    chk("expire2_mc", 32'(mudancaContexto), 32'h3);
    drive(1, 0, 32'h44, 0, 0, 2'd0, 0, 32'h0);
    drive(1, 0, 32'h44, 1, 0, 2'd0, 0, 32'h0);          // wraps back to slot 0
    chk("disp0_proc", 32'(proc_atual), 32'd0);
    chk("disp0_npc",  next_pc,         32'h14);
    drive(1, 0, 32'h14, 0, 0, 2'd0, 0, 32'h0);

    // only slot 2 valid
    drive(0, 0, 32'h14, 0, 1, 2'd0, 0, 32'h0);
    drive(0, 0, 32'h14, 0, 1, 2'd1, 0, 32'h0);
    drive(0, 0, 32'h14, 0, 1, 2'd2, 1, 32'h80);
    drive(1, 0, 32'h14, 0, 0, 2'd0, 0, 32'h0);          // running slot invalid
    chk("invalid_run_mc", 32'(mudancaContexto), 32'h3);
    drive(1, 0, 32'h99, 0, 0, 2'd0, 0, 32'h0);
    drive(1, 0, 32'h99, 1, 0, 2'd0, 0, 32'h0);
    chk("disp2_npc",  next_pc,         32'h80);
    chk("disp2_proc", 32'(proc_atual), 32'd2);
    drive(1, 0, 32'h80, 0, 0, 2'd0, 0, 32'h0);
    for (int i = 0; i < 4; i++) drive(1, 1, 32'h80 + 32'(i), 0, 0, 2'd0, 0, 32'h0);
    chk("expire3_mc", 32'(mudancaContexto), 32'h3);
    drive(1, 0, 32'h84, 0, 0, 2'd0, 0, 32'h0);
    drive(1, 0, 32'h84, 1, 0, 2'd0, 0, 32'h0);
    chk("redisp_mc",   32'(mudancaContexto), 32'h2);
    chk("redisp_npc",  next_pc,              32'h84);
    chk("redisp_proc", 32'(proc_atual),      32'd2);
    drive(1, 0, 32'h84, 0, 0, 2'd0, 0, 32'h0);
    for (int i = 0; i < 4; i++) drive(1, 1, 32'h84 + 32'(i), 0, 0, 2'd0, 0, 32'h0);
    drive(1, 0, 32'h88, 0, 0, 2'd0, 0, 32'h0);          // now in SCHED

    // nothing valid while scheduling
    drive(1, 0, 32'h0, 0, 1, 2'd2, 0, 32'h0);
    drive(1, 0, 32'h0, 1, 0, 2'd0, 0, 32'h0);
    chk("none_idle", 32'(idle),            32'h1);
    chk("none_mc",   32'(mudancaContexto), 32'h0);
    drive(1, 0, 32'h0, 0, 0, 2'd0, 0, 32'h0);
    chk("none_idle_hold", 32'(idle), 32'h1);
    drive(1, 0, 32'h0, 0, 1, 2'd3, 1, 32'h20);
    chk("cfg_idle_hold", 32'(idle), 32'h1);
    drive(1, 0, 32'h0, 1, 0, 2'd0, 0, 32'h0);
    chk("disp3_mc",   32'(mudancaContexto), 32'h2);
    chk("disp3_npc",  next_pc,              32'h20);
    chk("disp3_proc", 32'(proc_atual),      32'd3);
    chk("disp3_idle", 32'(idle),            32'h0);

    // clear the running slot mid-slice
    drive(1, 0, 32'h20, 0, 0, 2'd0, 0, 32'h0);
    drive(1, 1, 32'h20, 0, 0, 2'd0, 0, 32'h0);
    chk("kill_cnt", 32'(quantum_cnt), 32'd1);
    drive(1, 0, 32'h21, 0, 1, 2'd3, 0, 32'h0);
    chk("kill_mc", 32'(mudancaContexto), 32'h3);
    drive(1, 0, 32'h21, 0, 0, 2'd0, 0, 32'h0);
    chk("kill_sched_proc", 32'(proc_atual), 32'd3);

    // asynchronous reset while in SCHED
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // randomized traffic, model compared every cycle
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      reset      = ($urandom_range(0, 399) != 0);
      enable     = ($urandom_range(0, 99) < 85);
      retire     = ($urandom_range(0, 99) < 70);
      pc_atual   = $urandom;
      sched_done = ($urandom_range(0, 99) < 15);
      cfg_we     = ($urandom_range(0, 99) < 10);
      cfg_id     = 2'($urandom_range(0, NP - 1));
      cfg_valid  = ($urandom_range(0, 99) < 60);
      cfg_pc     = $urandom;
    end
    @(negedge clock);
    @(posedge clock);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
